// File: rtl/alu_mdu.sv
// EX-stage datapath: combinational integer ALU plus a multi-cycle multiply/divide
// unit that owns the architectural HI/LO registers.
module alu_mdu #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_W    = 5,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         alu_op,
    output logic [WIDTH-1:0]   alu_out,
    input  logic [2:0]         md_op,
    input  logic               start,
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [SHAMT_W-1:0] w_shamt;
    assign w_shamt = a[SHAMT_W-1:0];

    always_comb begin
        alu_out = '0;
        case (alu_op)
            4'd0:    alu_out = a + b;
            4'd1:    alu_out = a - b;
            4'd2:    alu_out = a | b;
            4'd3:    alu_out = b << w_shamt;
            4'd4:    alu_out = a & b;
            4'd5:    alu_out = a ^ b;
            4'd6:    alu_out = ~(a | b);
            4'd7:    alu_out = b >> w_shamt;
            4'd8:    alu_out = $signed(b) >>> w_shamt;
            4'd9:    alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd10:   alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd11:   alu_out = b << (WIDTH/2);
            default: alu_out = '0;
        endcase
    end

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Result is computed from latched operands; the countdown gives it a multi-cycle path.
    logic               w_smul;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;

    assign w_smul  = (r_op == 3'd1);
    assign w_ext_a = {{WIDTH{w_smul & r_a[WIDTH-1]}}, r_a};
    assign w_ext_b = {{WIDTH{w_smul & r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    logic             w_sdiv;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_den;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    // Signed divide on magnitudes; most-negative / -1 wraps back to the dividend naturally.
    assign w_sdiv  = (r_op == 3'd3);
    assign w_neg_a = w_sdiv & r_a[WIDTH-1];
    assign w_neg_b = w_sdiv & r_b[WIDTH-1];
    assign w_mag_a = w_neg_a ? -r_a : r_a;
    assign w_mag_b = w_neg_b ? -r_b : r_b;
    assign w_den   = (w_mag_b == '0) ? WIDTH'(1) : w_mag_b;
    assign w_q     = w_mag_a / w_den;
    assign w_r     = w_mag_a % w_den;
    assign w_quot  = (w_neg_a ^ w_neg_b) ? -w_q : w_q;
    assign w_rem   = w_neg_a ? -w_r : w_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                if (r_op == 3'd1 || r_op == 3'd2) begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end else if (r_b != '0) begin
                    r_hi <= w_rem;
                    r_lo <= w_quot;
                end
            end
        end else if (start) begin
            case (md_op)
                3'd1, 3'd2: begin
                    r_op  <= md_op;
                    r_a   <= a;
                    r_b   <= b;
                    r_cnt <= CNT_W'(MUL_CYCLES);
                end
                3'd3, 3'd4: begin
                    r_op  <= md_op;
                    r_a   <= a;
                    r_b   <= b;
                    r_cnt <= CNT_W'(DIV_CYCLES);
                end
                3'd5:    r_hi <= a;
                3'd6:    r_lo <= a;
                default: ;
            endcase
        end
    end

    assign busy = (r_cnt != '0);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle datapath ALU: a combinational integer ALU plus a multi-cycle multiply/divide unit (MDU) with architectural HI/LO registers.
- Sits in the EX stage. The ALU result is available in the same cycle. MDU operations raise busy for a fixed number of cycles; the hazard unit stalls on busy or start.

Parameters:
- WIDTH, 32, operand/result width in bits (≥8, power of 2).
- SHAMT_W, 5, shift-amount bits taken from a[SHAMT_W-1:0]; must equal log2(WIDTH).
- MUL_CYCLES, 5, busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (≥1).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- a  in  WIDTH  operand 1 (rs; shift amount for shifts).
- b  in  WIDTH  operand 2 (rt/imm; shifted value).
- alu_op  in  4  ALU function select.
- alu_out  out  WIDTH  combinational ALU result.
- md_op  in  3  MDU function: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- start  in  1  issue md_op this cycle (qualifies md_op).
- busy  out  1  MDU operation in progress.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), sampled only on the rising edge of clk.

ALU (combinational, no latency):
- alu_op encodings: 0 add, 1 sub, 2 or, 3 sll (b << a[SHAMT_W-1:0]), 4 and, 5 xor, 6 nor, 7 srl, 8 sra, 9 slt (signed, result 1/0), 10 sltu, 11 lui (b << WIDTH/2).
- Add and sub wrap modulo 2^WIDTH; no overflow flag.
- Encodings 12–15 give 0.

MDU:
- Reset: busy=0, hi=0, lo=0, internal counter=0, and any pending result discarded. Reset wins over a simultaneous start.
- Start acceptance: a start with md_op 1–4 is accepted on a rising edge only when busy=0.
  - Operands and op are latched at that edge.
  - The counter loads MUL_CYCLES (ops 1–2) or DIV_CYCLES (ops 3–4).
  - busy = (counter != 0), so busy rises the cycle after the start edge.
- Countdown:
  - The counter decrements on each edge while nonzero.
  - On the edge where the counter goes 1→0, hi/lo take the result.
  - So busy is high for exactly N cycles, and new hi/lo are visible in the first cycle busy is low.
- mult/multu: the {hi,lo} 2*WIDTH-bit product, signed/unsigned respectively.
- div/divu:
  - lo = quotient, hi = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Signed overflow (a = most-negative, b = -1): lo = a, hi = 0.
  - Divide by zero: busy still runs DIV_CYCLES; hi/lo remain unchanged.
- mthi/mtlo:
  - With start and busy=0, hi (or lo) = a at that edge.
  - No busy cycles; the value is visible the next cycle.
- Start while busy=1: ignored entirely. Operands, counter and hi/lo are unaffected; the in-flight result still commits.
- md_op 0 or 7 with start: no effect.
- Operand changes after the start edge do not affect the in-flight result.
- Back-to-back: a start in the first cycle with busy=0 after completion is accepted normally.
- Reset asserted mid-operation: at that edge busy=0 and hi=lo=0; no late commit.

Test Plan:
- ALU sweep: a=5, b=0xFFFFFFFF. add→4, sub→6, sltu→1, slt→0, sra (a=4)→0xFFFFFFFF, srl (a=4)→0x0FFFFFFF, lui b=0x1234→0x12340000, alu_op=13→0.
- mult a=0xFFFFFFFF (-1), b=2: busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands gives hi=1, lo=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9), b=2: busy 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu a=7, b=2 gives lo=3, hi=1.
- Edge cases:
  - div by zero after mthi 0xAA / mtlo 0xBB: busy 10 cycles, then hi=0xAA, lo=0xBB unchanged.
  - div a=0x80000000, b=-1: lo=0x80000000, hi=0.
- Hazards:
  - mult 3×4 is issued; in busy cycle 2, start with div 9/3 and a change to a → ignored; result hi=0, lo=12.
  - mtlo 0x55 issued while busy → lo=12 (mtlo ignored).
  - New mult issued in the first non-busy cycle → accepted.
- Reset mid-mult in busy cycle 3: the next cycle has busy=0, hi=lo=0, and hi/lo stay 0 after the original completion time.
